// File: rtl/knn_pkg.sv
// Shared types and helpers for the KNN dataset writer: FSM state encoding,
// default LFSR feedback taps and the total word count of one generated run.
package knn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_WRITE,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam logic [6:0] DEFAULT_TAPS = 7'b1011100;

  function automatic int unsigned total_words(input int unsigned t_elems,
                                               input int unsigned i_elems,
                                               input int unsigned words_per_elem);
    return (t_elems + i_elems) * words_per_elem;
  endfunction

endpackage

// File: rtl/knn_lfsr.sv
// XNOR-feedback Fibonacci LFSR that steps once per asserted advance and
// reloads SEED on synchronous active-low reset.
module knn_lfsr
  import knn_pkg::*;
#(
  parameter int unsigned        LFSR_W = 7,
  parameter logic [LFSR_W-1:0]  TAPS   = LFSR_W'(DEFAULT_TAPS),
  parameter logic [LFSR_W-1:0]  SEED   = LFSR_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  output logic [LFSR_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      value <= SEED;
    end else if (advance) begin
      value <= {value[LFSR_W-2:0], ~^(value & TAPS)};
    end
  end

endmodule

// File: rtl/knn_dataset_writer.sv
// Generates a pseudo-random labelled training set plus an unlabelled input set
// and writes it to SDRAM; afterwards the write port is handed to the client bus.
// Optional feature macro: KNN_DSGEN_CLASS_HIST_EN adds per-class label counters.
module knn_dataset_writer
  import knn_pkg::*;
#(
  parameter int unsigned       W              = 16,
  parameter int unsigned       ADDR_W         = 25,
  parameter int unsigned       WORDS_PER_ELEM = 60,
  parameter int unsigned       T_ELEMS        = 64,
  parameter int unsigned       I_ELEMS        = 10,
  parameter int unsigned       NUM_CLASSES    = 5,
  parameter int unsigned       FEAT_RANGE     = 100,
  parameter int unsigned       LFSR_W         = 7,
  parameter logic [LFSR_W-1:0] TAPS           = LFSR_W'(DEFAULT_TAPS),
  parameter logic [LFSR_W-1:0] SEED           = LFSR_W'(1),
  parameter logic [ADDR_W-1:0] BASE_T_ADDR    = '0,
  parameter logic [ADDR_W-1:0] BASE_I_ADDR    = ADDR_W'(1) << (ADDR_W-1),
  parameter int unsigned       ADDR_STRIDE    = W,
  parameter int unsigned       WR_GAP         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_button,
  input  logic              write_waitrequest,
  input  logic              client_write,
  input  logic [ADDR_W-1:0] client_writeaddress,
  input  logic [W-1:0]      client_writedata,
  output logic              write,
  output logic [ADDR_W-1:0] writeaddress,
  output logic [W-1:0]      writedata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       words_written
`ifdef KNN_DSGEN_CLASS_HIST_EN
  , output logic [NUM_CLASSES*16-1:0] class_hist
`endif
);

  localparam int unsigned TOTAL = total_words(T_ELEMS, I_ELEMS, WORDS_PER_ELEM);

  state_t              state, state_next;
  logic                sync1, sync2, sync2_d;
  logic                start_edge, pending, take_start;
  logic                write_r, busy_r, done_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [W-1:0]        data_r, gen_data;
  logic [31:0]         elem_cnt, word_cnt, gap_cnt;
  logic [LFSR_W-1:0]   lfsr_value;
  logic [31:0]         lfsr_ext;
  logic                accept, last_word_in_elem, last_train_word, final_word;

  knn_lfsr #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .SEED   (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (state == ST_GEN),
    .value   (lfsr_value)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= start_button;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign start_edge        = sync2 & ~sync2_d;
  assign accept            = (state == ST_WRITE) && !write_waitrequest;
  assign last_word_in_elem = (word_cnt == WORDS_PER_ELEM - 1);
  assign last_train_word   = last_word_in_elem && (elem_cnt == T_ELEMS - 1);
  assign final_word        = (words_written == TOTAL - 1);
  assign lfsr_ext          = 32'(lfsr_value);

  // A start is held back while the client drives a transfer so it is never cut short.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending <= 1'b0;
    end else if (take_start) begin
      pending <= 1'b0;
    end else if (start_edge && !busy_r) begin
      pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    take_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((start_edge || pending) && !(done_r && client_write)) begin
          take_start = 1'b1;
          state_next = ST_GEN;
        end
      end
      ST_GEN:   state_next = ST_WRITE;
      ST_WRITE: begin
        if (accept) begin
          if (final_word)       state_next = ST_DONE;
          else if (WR_GAP == 0) state_next = ST_GEN;
          else                  state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt == WR_GAP - 1) state_next = ST_GEN;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    gen_data = '0;
    if (word_cnt != 0) begin
      gen_data = W'(lfsr_ext % FEAT_RANGE);
    end else if (elem_cnt < T_ELEMS) begin
      gen_data = W'((lfsr_ext % NUM_CLASSES) + 1);
    end
  end

  // The jump to the input-set base happens on the accept of the last training word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      write_r       <= 1'b0;
      addr_r        <= '0;
      data_r        <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      words_written <= '0;
      elem_cnt      <= '0;
      word_cnt      <= '0;
      gap_cnt       <= '0;
    end else begin
      if (take_start) begin
        busy_r        <= 1'b1;
        done_r        <= 1'b0;
        words_written <= '0;
        elem_cnt      <= '0;
        word_cnt      <= '0;
        addr_r        <= BASE_T_ADDR;
      end
      case (state)
        ST_GEN: begin
          data_r  <= gen_data;
          write_r <= 1'b1;
        end
        ST_WRITE: begin
          if (accept) begin
            write_r       <= 1'b0;
            words_written <= words_written + 32'd1;
            gap_cnt       <= '0;
            if (final_word) begin
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end
            if (last_word_in_elem) begin
              word_cnt <= '0;
              elem_cnt <= elem_cnt + 32'd1;
            end else begin
              word_cnt <= word_cnt + 32'd1;
            end
            addr_r <= last_train_word ? BASE_I_ADDR : addr_r + ADDR_W'(ADDR_STRIDE);
          end
        end
        ST_GAP:  gap_cnt <= gap_cnt + 32'd1;
        default: ;
      endcase
    end
  end

`ifdef KNN_DSGEN_CLASS_HIST_EN
  logic [NUM_CLASSES-1:0][15:0] hist_q;

  always_ff @(posedge clk) begin
    if (!rst || take_start) begin
      hist_q <= '0;
    end else if (accept && word_cnt == 0 && elem_cnt < T_ELEMS) begin
      for (int c = 0; c < int'(NUM_CLASSES); c++) begin
        if (data_r == W'(c + 1) && hist_q[c] != 16'hFFFF) begin
          hist_q[c] <= hist_q[c] + 16'd1;
        end
      end
    end
  end

  assign class_hist = hist_q;
`endif

  assign write        = done_r ? client_write        : write_r;
  assign writeaddress = done_r ? client_writeaddress : addr_r;
  assign writedata    = done_r ? client_writedata    : data_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_knn_dataset_writer.sv
// Directed bench for knn_dataset_writer with a reduced dataset (3 training +
// 2 input elements of 4 words, WR_GAP=1); writes are captured and checked.
module tb_knn_dataset_writer;

  localparam int NW = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_button;
  logic        write_waitrequest;
  logic        client_write;
  logic [24:0] client_writeaddress;
  logic [15:0] client_writedata;
  logic        write;
  logic [24:0] writeaddress;
  logic [15:0] writedata;
  logic        busy;
  logic        done;
  logic [31:0] words_written;
`ifdef KNN_DSGEN_CLASS_HIST_EN
  logic [5*16-1:0] class_hist;
`endif

  int errors = 0;
  int checks = 0;
  int stall_mode = 0;
  int cap_n = 0;
  logic [24:0] cap_addr [0:63];
  logic [15:0] cap_data [0:63];
  logic [15:0] run1_data [0:NW-1];
  logic [6:0]  model_lfsr;
  logic        prev_stalled = 1'b0;
  logic [24:0] prev_addr;
  logic [15:0] prev_data;

  knn_dataset_writer #(
    .WORDS_PER_ELEM (4),
    .T_ELEMS        (3),
    .I_ELEMS        (2),
    .WR_GAP         (1)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start_button        (start_button),
    .write_waitrequest   (write_waitrequest),
    .client_write        (client_write),
    .client_writeaddress (client_writeaddress),
    .client_writedata    (client_writedata),
    .write               (write),
    .writeaddress        (writeaddress),
    .writedata           (writedata),
    .busy                (busy),
    .done                (done),
    .words_written       (words_written)
`ifdef KNN_DSGEN_CLASS_HIST_EN
    , .class_hist        (class_hist)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    start_button = 1'b1;
    tick(3);
    start_button = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 3000) begin
      tick(1);
      n++;
    end
    checkOutput(tag, 32'(done), 32'd1);
  endtask

  // Reference sequence: XNOR LFSR from the model state, labels/features by word slot.
  task automatic compare_run(input string tag);
    logic [24:0] ea;
    logic [15:0] ed;
    logic        fb;
    int          elem, w;
    for (int k = 0; k < NW; k++) begin
      elem = k / 4;
      w    = k % 4;
      if (w == 0) ed = (elem < 3) ? 16'((model_lfsr % 5) + 1) : 16'd0;
      else        ed = 16'(model_lfsr % 100);
      ea = (elem < 3) ? 25'(k * 16) : 25'h1000000 + 25'((k - 12) * 16);
      fb = ~^(model_lfsr & 7'b1011100);
      model_lfsr = {model_lfsr[5:0], fb};
      if (k < cap_n) begin
        checkOutput({tag, "_addr"}, 32'(cap_addr[k]), 32'(ea));
        checkOutput({tag, "_data"}, 32'(cap_data[k]), 32'(ed));
      end
    end
  endtask

  // Waitrequest driver and accept monitor, sampling on the falling edge.
  initial begin
    logic wr;
    write_waitrequest = 1'b0;
    forever begin
      @(negedge clk);
      if (busy && write && prev_stalled) begin
        checkOutput("stall_addr", 32'(writeaddress), 32'(prev_addr));
        checkOutput("stall_data", 32'(writedata), 32'(prev_data));
      end
      case (stall_mode)
        0:       wr = 1'b0;
        1:       wr = ($urandom_range(0, 9) < 3);
        default: wr = 1'b1;
      endcase
      write_waitrequest = wr;
      if (busy && write && !wr) begin
        if (cap_n < 64) begin
          cap_addr[cap_n] = writeaddress;
          cap_data[cap_n] = writedata;
        end
        cap_n++;
      end
      prev_stalled = busy && write && wr;
      prev_addr    = writeaddress;
      prev_data    = writedata;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   n;
    logic differs;
    rst = 1'b0;
    start_button = 1'b0;
    client_write = 1'b0;
    client_writeaddress = '0;
    client_writedata = '0;
    tick(3);
    checkOutput("rst_write", 32'(write), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_words", words_written, 32'd0);
    checkOutput("rst_addr", 32'(writeaddress), 32'd0);
    rst = 1'b1;
    tick(2);

    // Run 1: no stalls, latency and pacing
    cap_n = 0;
    model_lfsr = 7'd1;
    stall_mode = 0;
    start_button = 1'b1;
    n = 0;
    while (!write && n < 20) begin
      tick(1);
      n++;
    end
    checkOutput("start_latency", n, 4);
    checkOutput("first_busy", 32'(busy), 32'd1);
    checkOutput("first_words", words_written, 32'd0);
    tick(1);
    checkOutput("after_accept_write", 32'(write), 32'd0);
    checkOutput("after_accept_words", words_written, 32'd1);
    n = 0;
    while (!write && n < 20) begin
      tick(1);
      n++;
    end
    checkOutput("word_period", n + 1, 3);
    start_button = 1'b0;
    wait_done("run1_done");
    checkOutput("run1_count", cap_n, NW);
    checkOutput("run1_words", words_written, NW);
    checkOutput("run1_busy", 32'(busy), 32'd0);
    checkOutput("hand_d0", 32'(cap_data[0]), 32'd2);
    checkOutput("hand_d1", 32'(cap_data[1]), 32'd3);
    checkOutput("hand_d2", 32'(cap_data[2]), 32'd7);
    checkOutput("hand_d3", 32'(cap_data[3]), 32'd14);
    checkOutput("hand_d4", 32'(cap_data[4]), 32'd5);
    checkOutput("hand_a4", 32'(cap_addr[4]), 32'd64);
    checkOutput("last_train_addr", 32'(cap_addr[11]), 32'd176);
    checkOutput("first_input_addr", 32'(cap_addr[12]), 32'h1000000);
    checkOutput("first_input_data", 32'(cap_data[12]), 32'd0);
    compare_run("run1");
    for (int k = 0; k < NW; k++) run1_data[k] = cap_data[k];

    // Client owns the bus once done
    client_write = 1'b1;
    client_writeaddress = 25'h0ABCDE;
    client_writedata = 16'hBEEF;
    #1;
    checkOutput("client_write", 32'(write), 32'd1);
    checkOutput("client_addr", 32'(writeaddress), 32'h0ABCDE);
    checkOutput("client_data", 32'(writedata), 32'hBEEF);
    client_write = 1'b0;
    #1;
    checkOutput("client_write_low", 32'(write), 32'd0);

    // Run 2: start deferred by the client, random stalls
    client_write = 1'b1;
    cap_n = 0;
    stall_mode = 1;
    start_button = 1'b1;
    tick(12);
    start_button = 1'b0;
    checkOutput("deferred_busy", 32'(busy), 32'd0);
    checkOutput("deferred_done", 32'(done), 32'd1);
    client_write = 1'b0;
    n = 0;
    while (!busy && n < 10) begin
      tick(1);
      n++;
    end
    checkOutput("deferred_taken", 32'(busy), 32'd1);
    checkOutput("deferred_done_clr", 32'(done), 32'd0);
    wait_done("run2_done");
    stall_mode = 0;
    checkOutput("run2_count", cap_n, NW);
    compare_run("run2");
    differs = 1'b0;
    for (int k = 0; k < NW; k++) if (cap_data[k] != run1_data[k]) differs = 1'b1;
    checkOutput("run2_differs", 32'(differs), 32'd1);

    // Run 3: reset during a stalled write
    cap_n = 0;
    applyStimulus();
    n = 0;
    while (words_written < 5 && n < 200) begin
      tick(1);
      n++;
    end
    stall_mode = 2;
    n = 0;
    while (!(write && write_waitrequest) && n < 50) begin
      tick(1);
      n++;
    end
    checkOutput("stalled_write", 32'(write && write_waitrequest), 32'd1);
    rst = 1'b0;
    tick(1);
    checkOutput("midrst_write", 32'(write), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_words", words_written, 32'd0);
    checkOutput("midrst_addr", 32'(writeaddress), 32'd0);
    stall_mode = 0;
    rst = 1'b1;
    tick(2);

    // Run 4: reseeded LFSR reproduces run 1
    cap_n = 0;
    model_lfsr = 7'd1;
    applyStimulus();
    wait_done("run4_done");
    checkOutput("run4_count", cap_n, NW);
    compare_run("run4");
    differs = 1'b0;
    for (int k = 0; k < NW; k++) if (cap_data[k] != run1_data[k]) differs = 1'b1;
    checkOutput("rerun_same", 32'(differs), 32'd0);

`ifdef KNN_DSGEN_CLASS_HIST_EN
    begin
      int exp_cnt [5];
      int sum;
      sum = 0;
      for (int c = 0; c < 5; c++) exp_cnt[c] = 0;
      for (int e = 0; e < 3; e++) exp_cnt[cap_data[e*4] - 1]++;
      for (int c = 0; c < 5; c++) begin
        sum += int'(class_hist[c*16 +: 16]);
        checkOutput("hist_class", 32'(class_hist[c*16 +: 16]), exp_cnt[c]);
      end
      checkOutput("hist_sum", sum, 3);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/knn_dataset_writer.md
# knn_dataset_writer

Parametrised successor to the single-shot SDRAM test-pattern writer in the KNN system. It generates a pseudo-random labelled training set and an unlabelled input set, writes both to SDRAM over an Avalon-style write port with waitrequest back-pressure, and signals completion. After completion it hands the write port to the memory-control client. Unlike the previous generation, it supports configurable class count, feature range, element counts, address stride and write pacing, and can regenerate on a later start.

## Interface
- W, 16: data word width
- ADDR_W, 25: address width
- WORDS_PER_ELEM, 60: words per element (M*N); word 0 is the label
- T_ELEMS, 64: training elements
- I_ELEMS, 10: input elements
- NUM_CLASSES, 5: training labels 1..NUM_CLASSES
- FEAT_RANGE, 100: features 0..FEAT_RANGE-1
- LFSR_W, 7: LFSR width
- TAPS, 7'b1011100: feedback tap mask
- SEED, 1: reset LFSR value; must be nonzero
- BASE_T_ADDR, 0: training base address
- BASE_I_ADDR, 1<<(ADDR_W-1): input base address
- ADDR_STRIDE, W: address increment per word
- WR_GAP, 8: idle cycles after each accepted write
- clk  in  1  clock
- rst  in  1  reset; synchronous and active-low
- start_button  in  1  asynchronous push button
- write_waitrequest  in  1  slave stall
- client_write / client_writeaddress / client_writedata  in  1/ADDR_W/W  memory-control write bus
- write  out  1  SDRAM write strobe
- writeaddress  out  ADDR_W  SDRAM write address
- writedata  out  W  SDRAM write data
- busy  out  1  generation in progress
- done  out  1  last dataset fully written; client owns the bus
- words_written  out  32  accepted words in the current run

## Operation
- start_button passes through a 2-flop synchroniser. A rising edge on the synchronised signal makes a start request.
- Start handling:
  - A start is ignored while busy.
  - A start while done is latched as pending. It is taken only in a cycle where client_write=0; this prevents truncating a client transfer.
- On a start: busy=1, done=0, words_written=0, element counter=0, word counter=0, address=BASE_T_ADDR.
- LFSR:
  - Feedback bit = XNOR-reduce(lfsr & TAPS), shifted into bit 0.
  - Advances exactly once per generated word.
  - Not reseeded between runs, so a regeneration produces a new dataset.
- Word content:
  - Word 0 of a training element: (lfsr % NUM_CLASSES) + 1.
  - Word 0 of an input element: 0.
  - Other words: lfsr % FEAT_RANGE, zero-extended to W.
- Addressing:
  - address += ADDR_STRIDE per accepted word.
  - After the last word of element T_ELEMS-1, address = BASE_I_ADDR.
- States:
  - IDLE → GEN on start.
  - GEN (1 cycle): compute data and address, advance the LFSR → WRITE.
  - WRITE: write=1 with address and data held stable until write_waitrequest=0 (accept). On accept: → GAP, or → DONE if this was the last word of element T_ELEMS+I_ELEMS-1.
  - GAP: counts WR_GAP cycles → GEN. GAP is skipped when WR_GAP=0.
  - DONE: busy=0, done=1 → IDLE.
- Output mux: when done=1, the write outputs equal the client_* inputs combinationally. Otherwise they are driven by internal registers.
- Reset (rst=0) at any point, including mid-write:
  - write=0, writeaddress=0, writedata=0, busy=0, done=0, words_written=0.
  - LFSR=SEED, state=IDLE, pending start cleared.

## Timing
- Start edge to first write=1: 4 cycles (2 synchroniser, 1 edge detect, 1 GEN).
- Word period without stalls: WR_GAP+2 cycles. Each waitrequest cycle adds 1.
- words_written increments in the cycle after accept.
- done rises 1 cycle after the final accept. It is held until rst or a taken start.
- A start edge coincident with the final accept is ignored (busy still 1).

## Configuration
- KNN_DSGEN_CLASS_HIST_EN defined:
  - Adds output class_hist, NUM_CLASSES×16 bits.
  - One saturating counter per class, incremented on accept of each training word 0.
  - All counters cleared on reset and on a taken start.
- Undefined: the port and counters are absent.

## Structure
- Shared package knn_pkg:
  - State enum.
  - Default LFSR taps constant.
  - Total word count function (T_ELEMS+I_ELEMS)*WORDS_PER_ELEM.
- Sub-module knn_lfsr: parameters LFSR_W, TAPS, SEED; ports clk, rst, advance, value.

## Test plan
- Defaults, waitrequest=0, press button → 74×60=4440 writes; first at address 0 with label in 1..5; first input word at 1<<24 with data 0; done after the last write.
- Random waitrequest stalls (30%) → address/data stable across stalls; 4440 total accepts; dataset identical to the no-stall run.
- WR_GAP=0, T_ELEMS=2, I_ELEMS=1, WORDS_PER_ELEM=4 → 12 writes, one every 2 cycles; addresses 0,16,…,112 then 1<<24…
- After done, toggle client_write → outputs follow the client bus; button with client_write=1 → generation deferred until client_write=0; second dataset differs from the first.
- Assert rst=0 mid-WRITE during a stall → next cycle write=0, busy=0, done=0; rerun reproduces the first dataset (LFSR reseeded to SEED).
- KNN_DSGEN_CLASS_HIST_EN defined → sum of class_hist = 64 after a run; counts match the labels captured by the bench.
